// File: rtl/mem_port_arbiter_if.sv
// One requester port of mem_port_arbiter: req/gnt/done handshake plus access fields.
// master = requester (CPU or AUX side), slave = arbiter side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              done;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, done, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, done, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (CPU, AUX) arbiter serialising accesses to a single-port memory.
// Build option ARB_ROUND_ROBIN_EN: round-robin on contention instead of CPU priority + starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave cpu,
  mem_port_arbiter_if.slave aux,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int               LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
  localparam logic             PORT_CPU = 1'b0;
  localparam logic             PORT_AUX = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              aux_gnt_q, aux_gnt_d;
  logic              cpu_done_q, cpu_done_d;
  logic              aux_done_q, aux_done_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic              grant_aux;
  logic              gnt_any;
  logic              done_any;
  logic              win_we;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last_q, rr_last_d;
`else
  localparam int                  STARVE_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  logic [STARVE_W-1:0] starve_q, starve_d;
`endif

  // Arbitration decision, only consumed in IDLE
  always_comb begin
    grant_aux = 1'b0;
    if (cpu.req && aux.req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_aux = (rr_last_q == PORT_CPU);
`else
      grant_aux = (starve_q == STARVE_LIM);
`endif
    end else if (aux.req) begin
      grant_aux = 1'b1;
    end else begin
      grant_aux = 1'b0;
    end
  end

  // Next-state, datapath latches and next values of all registered outputs
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    lat_d       = lat_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    aux_rdata_d = aux_rdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    gnt_any     = 1'b0;
    done_any    = 1'b0;
    win_we      = grant_aux ? aux.we : cpu.we;
`ifdef ARB_ROUND_ROBIN_EN
    rr_last_d   = rr_last_q;
`else
    starve_d    = starve_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cpu.req || aux.req) begin
          state_d  = ST_ACCESS;
          owner_d  = grant_aux;
          we_d     = win_we;
          lat_d    = {LAT_W{1'b0}};
          addr_d   = grant_aux ? aux.addr : cpu.addr;
          wdata_d  = grant_aux ? aux.wdata : cpu.wdata;
          mem_we_d = win_we;
          mem_re_d = ~win_we;
          gnt_any  = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          rr_last_d = grant_aux;
`else
          // Count CPU wins only while AUX is actually waiting
          if (grant_aux) begin
            starve_d = {STARVE_W{1'b0}};
          end else if (aux.req && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + STARVE_W'(1);
          end else begin
            starve_d = starve_q;
          end
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        gnt_any = 1'b1;
        if (lat_q == LAT_LAST) begin
          state_d     = ST_DONE;
          done_any    = 1'b1;
          cpu_rdata_d = (!we_q && (owner_q == PORT_CPU)) ? mem_rdata : cpu_rdata_q;
          aux_rdata_d = (!we_q && (owner_q == PORT_AUX)) ? mem_rdata : aux_rdata_q;
        end else begin
          lat_d    = lat_q + LAT_W'(1);
          mem_re_d = ~we_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cpu_gnt_d  = gnt_any  & (owner_d == PORT_CPU);
    aux_gnt_d  = gnt_any  & (owner_d == PORT_AUX);
    cpu_done_d = done_any & (owner_d == PORT_CPU);
    aux_done_d = done_any & (owner_d == PORT_AUX);
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= PORT_CPU;
      we_q        <= 1'b0;
      lat_q       <= {LAT_W{1'b0}};
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      cpu_rdata_q <= {DATA_W{1'b0}};
      aux_rdata_q <= {DATA_W{1'b0}};
      cpu_gnt_q   <= 1'b0;
      aux_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      aux_done_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q   <= PORT_AUX;
`else
      starve_q    <= {STARVE_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      lat_q       <= lat_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      aux_rdata_q <= aux_rdata_d;
      cpu_gnt_q   <= cpu_gnt_d;
      aux_gnt_q   <= aux_gnt_d;
      cpu_done_q  <= cpu_done_d;
      aux_done_q  <= aux_done_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q   <= rr_last_d;
`else
      starve_q    <= starve_d;
`endif
    end
  end

  assign cpu.gnt   = cpu_gnt_q;
  assign cpu.done  = cpu_done_q;
  assign cpu.rdata = cpu_rdata_q;
  assign aux.gnt   = aux_gnt_q;
  assign aux.done  = aux_done_q;
  assign aux.rdata = aux_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule
